prf_multiport: RTL
==================

Name: prf_multiport

Overview:
Parametrised physical register file for the OoO core. It generalises the fixed 6-read/2-write PRF to NUM_RD read ports and NUM_WR writeback ports. It adds a per-register ready (scoreboard) table driven by rename allocation and CDB writeback, and a registered write-conflict flag. It sits between rename/issue (reads, allocation) and the writeback/CDB stage.

Parameters:
DATA_WIDTH, 32, register data width
PREG_WIDTH, 7, physical register index width; NUM_PREGS = 2**PREG_WIDTH
NUM_RD, 6, number of combinational read ports
NUM_WR, 2, number of writeback ports
NUM_ALLOC, 1, number of rename allocation ports per cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*PREG_WIDTH  read addresses; port i at slice [i*PREG_WIDTH +: PREG_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  read data, same slicing
rd_ready  out  NUM_RD  ready bit of the addressed preg
alloc_valid  in  NUM_ALLOC  allocation strobe per port
alloc_preg  in  NUM_ALLOC*PREG_WIDTH  newly allocated destination preg
wb_valid  in  NUM_WR  writeback strobe per port
wb_dest  in  NUM_WR*PREG_WIDTH  writeback destination preg
wb_data  in  NUM_WR*DATA_WIDTH  writeback data
flush  in  1  pipeline flush: mark all pregs ready
wr_conflict  out  1  registered: two or more valid wb ports targeted the same nonzero preg last cycle

Behaviour:
- Reset (clk edge with reset=1):
  - all data registers = 0; all ready bits = 1; wr_conflict = 0.
  - Overrides flush, alloc and wb in the same cycle.
- P0:
  - reads always return data 0, ready 1.
  - wb and alloc targeting P0 are ignored; no conflict is counted for P0.
- Write: on clk edge, for each port j with wb_valid[j] and wb_dest[j] != 0, registers[wb_dest[j]] <= wb_data[j] and ready <= 1.
- Same-dest multi-write: the highest-index port wins the data. wr_conflict is 1 for exactly the following cycle.
- Alloc: on clk edge, for each valid alloc port, ready[alloc_preg] <= 0. Data is unchanged.
- Alloc and wb to the same preg in the same cycle: alloc wins, so ready = 0. Data is still written.
- Flush: on clk edge, all ready bits <= 1 (P0 included).
  - Flush has priority over alloc in the same cycle.
  - wb data writes still occur in the flush cycle.
- Read: purely combinational from stored state, with 0-cycle latency.
  - Without bypass, a same-cycle write becomes visible the cycle after the edge.
- Widths: all indices are unsigned. There is no wrap; every PREG_WIDTH value addresses a real register.

Optional Feature:
PRF_WB_BYPASS_EN
- Defined:
  - Each read port compares rd_addr against every valid nonzero wb_dest in the same cycle.
  - On a match, rd_data = the matching wb_data (highest-index port on multi-match) and rd_ready = 1.
  - This lets issue see a result in its writeback cycle.
  - The bypass ignores alloc.
- Undefined: no bypass; reads reflect stored state only, as above.

Test Plan:
- Reset, then read all 128 pregs -> data 0, ready 1 everywhere; wr_conflict 0.
- alloc P5; next cycle wb P5=0xDEADBEEF -> rd P5 shows ready 0 after the alloc edge. After the wb edge it shows ready 1, data 0xDEADBEEF. With PRF_WB_BYPASS_EN, data and ready 1 are visible in the wb cycle itself.
- wb port0 P9=0x11, port1 P9=0x22 same cycle -> P9 = 0x22; wr_conflict = 1 for one cycle, then 0.
- wb P0=0xFFFF and alloc P0 -> rd P0 still 0, ready 1; no conflict.
- alloc P7 and P8 in consecutive cycles, then flush with alloc P10 in the same cycle -> P7, P8, P10 all ready 1 after the flush edge. Data is unchanged.
- Mid-sequence reset with wb P3=0x55 in the same cycle -> P3 data 0, ready 1; wr_conflict 0.

Source files
------------

// File: rtl/prf_multiport.sv
// prf_multiport: parametrised physical register file with NUM_RD combinational
// read ports, NUM_WR writeback ports, a per-register ready table (cleared by
// rename allocation, set by writeback or flush) and a registered write-conflict flag.
// Optional build macro: PRF_WB_BYPASS_EN forwards same-cycle writeback data to reads.
// P0 is hardwired: reads return data 0 / ready 1, and writes/allocs to it are dropped.

module prf_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int PREG_WIDTH = 7,
  parameter int NUM_RD     = 6,
  parameter int NUM_WR     = 2,
  parameter int NUM_ALLOC  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD*PREG_WIDTH-1:0]    rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]               rd_ready,
  input  logic [NUM_ALLOC-1:0]            alloc_valid,
  input  logic [NUM_ALLOC*PREG_WIDTH-1:0] alloc_preg,
  input  logic [NUM_WR-1:0]               wb_valid,
  input  logic [NUM_WR*PREG_WIDTH-1:0]    wb_dest,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wb_data,
  input  logic                            flush,
  output logic                            wr_conflict
);

  localparam int NUM_PREGS = 2 ** PREG_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_PREGS];
  logic [NUM_PREGS-1:0]  ready_q;
  logic [NUM_WR-1:0]     wb_live;
  logic                  conflict_c;

  // A writeback port only counts when it is valid and not aimed at P0.
  always_comb begin
    wb_live = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wb_live[j] = wb_valid[j] && (wb_dest[j*PREG_WIDTH +: PREG_WIDTH] != '0);
    end
  end

  // Detect two or more live writeback ports hitting the same preg this cycle.
  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wb_live[i] && wb_live[j] &&
            (wb_dest[i*PREG_WIDTH +: PREG_WIDTH] == wb_dest[j*PREG_WIDTH +: PREG_WIDTH])) begin
          conflict_c = 1'b1;
        end
      end
    end
  end

  // State update: writeback sets data/ready (later ports override earlier ones),
  // then flush or allocation overrides the ready bits; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PREGS; p++) begin
        regs[p] <= '0;
      end
      ready_q     <= '1;
      wr_conflict <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wb_live[j]) begin
          regs[wb_dest[j*PREG_WIDTH +: PREG_WIDTH]]    <= wb_data[j*DATA_WIDTH +: DATA_WIDTH];
          ready_q[wb_dest[j*PREG_WIDTH +: PREG_WIDTH]] <= 1'b1;
        end
      end
      if (flush) begin
        ready_q <= '1;
      end else begin
        for (int a = 0; a < NUM_ALLOC; a++) begin
          if (alloc_valid[a] && (alloc_preg[a*PREG_WIDTH +: PREG_WIDTH] != '0)) begin
            ready_q[alloc_preg[a*PREG_WIDTH +: PREG_WIDTH]] <= 1'b0;
          end
        end
      end
      wr_conflict <= conflict_c;
    end
  end

  // Read ports: stored state, with P0 forced to 0/ready and optional wb forwarding.
  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_addr[i*PREG_WIDTH +: PREG_WIDTH] == '0) begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_ready[i]                         = 1'b1;
      end else begin
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr[i*PREG_WIDTH +: PREG_WIDTH]];
        rd_ready[i]                         = ready_q[rd_addr[i*PREG_WIDTH +: PREG_WIDTH]];
`ifdef PRF_WB_BYPASS_EN
        // Ascending scan so the highest-index matching port wins.
        for (int j = 0; j < NUM_WR; j++) begin
          if (wb_live[j] &&
              (wb_dest[j*PREG_WIDTH +: PREG_WIDTH] == rd_addr[i*PREG_WIDTH +: PREG_WIDTH])) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wb_data[j*DATA_WIDTH +: DATA_WIDTH];
            rd_ready[i]                         = 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule
